// File: rtl/decode_scoreboard_pkg.sv
// decode_scoreboard_pkg: shared FSM encodings and constants for the decode scoreboard
package decode_scoreboard_pkg;
  typedef enum logic {L_IDLE, L_WAIT} ldState_t;
  typedef enum logic {M_IDLE, M_BUSY} mduState_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int DEF_MDU_LAT = 4;
  localparam int DEF_FPU_LAT = 3;
  localparam int DEF_CNT_W = 3;
endpackage

// File: rtl/sb_latency_counter.sv
// sb_latency_counter: per-register result latency counter, loads on issue and counts down to zero
module sb_latency_counter #(
  parameter int CNT_W = 3
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iLoad,
  input  logic [CNT_W-1:0] iLoadVal,
  output logic             oBusy
);
  logic [CNT_W-1:0] cnt;
  assign oBusy = cnt != '0;
  always_ff @(posedge iClk or negedge iRst_n)
    if (!iRst_n) cnt <= '0;
    else if (iLoad) cnt <= iLoadVal;
    else if (oBusy) cnt <= cnt - 1'b1;
endmodule

// File: rtl/decode_scoreboard.sv
// decode_scoreboard: tracks in-flight multi-cycle destinations and stalls decode on RAW/WAW/structural hazards
module decode_scoreboard
  import decode_scoreboard_pkg::*;
#(
  parameter int MDU_LAT = DEF_MDU_LAT,
  parameter int FPU_LAT = DEF_FPU_LAT,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iValid,
  input  logic        iFlush,
  input  logic [4:0]  iSrc0Addr,
  input  logic [4:0]  iSrc1Addr,
  input  logic        iSrc0En,
  input  logic        iSrc1En,
  input  logic [4:0]  iWriteAddr,
  input  logic        iWriteEn,
  input  logic        iMduOp,
  input  logic        iFpuCmd,
  input  logic        iLoadCmd,
  input  logic        iLoadDone,
  output logic        oStall,
  output logic [31:0] oPending,
  output logic        oMduBusy,
  output logic        oLoadBusy
);
  ldState_t ldState, ldNext;
  mduState_t mduState, mduNext;
  logic [4:0] ldTag, ldTagNext;
  logic [CNT_W-1:0] mduCnt, mduCntNext;
  logic [31:0] cntBusy, ldMask;
  logic issue, trackWrite, cntLoadEn;
  logic rawStall0, rawStall1, wawStall, mduStall, ldStall;
  logic [CNT_W-1:0] latVal;
  assign trackWrite = iWriteEn & (iWriteAddr != REG_ZERO);
  assign latVal = iMduOp ? CNT_W'(MDU_LAT) : CNT_W'(FPU_LAT);
  assign cntLoadEn = issue & trackWrite & (iMduOp | iFpuCmd);
  assign cntBusy[0] = 1'b0;
  for (genvar r = 1; r < 32; r++) begin : gCnt
    sb_latency_counter #(.CNT_W(CNT_W)) uCnt (
      .iClk    (iClk),
      .iRst_n  (iRst_n),
      .iLoad   (cntLoadEn && iWriteAddr == 5'(r)),
      .iLoadVal(latVal),
      .oBusy   (cntBusy[r])
    );
  end
  assign ldMask = (ldState == L_WAIT) ? (32'd1 << ldTag) : 32'd0;
  assign oPending = (cntBusy | ldMask) & ~32'd1;
  assign oMduBusy = mduState == M_BUSY;
  assign oLoadBusy = ldState == L_WAIT;
  assign rawStall0 = iSrc0En & (iSrc0Addr != REG_ZERO) & oPending[iSrc0Addr];
  assign rawStall1 = iSrc1En & (iSrc1Addr != REG_ZERO) & oPending[iSrc1Addr];
  assign wawStall = trackWrite & oPending[iWriteAddr];
  assign mduStall = iMduOp & oMduBusy;
  assign ldStall = iLoadCmd & oLoadBusy;
  // Flush squashes issue but leaves the stall visible to fetch
  assign oStall = iValid & (rawStall0 | rawStall1 | wawStall | mduStall | ldStall);
  assign issue = iValid & ~iFlush & ~oStall;
  always_comb begin
    ldNext = ldState;
    ldTagNext = ldTag;
    mduNext = mduState;
    mduCntNext = mduCnt;
    if (ldState == L_IDLE && issue && iLoadCmd) begin
      ldNext = L_WAIT;
      ldTagNext = trackWrite ? iWriteAddr : REG_ZERO;
    end else if (ldState == L_WAIT && iLoadDone) begin
      ldNext = L_IDLE;
    end
    if (issue && iMduOp) begin
      mduNext = M_BUSY;
      mduCntNext = CNT_W'(MDU_LAT);
    end else if (mduState == M_BUSY) begin
      mduCntNext = mduCnt - 1'b1;
      mduNext = (mduCnt == CNT_W'(1)) ? M_IDLE : M_BUSY;
    end
  end
  always_ff @(posedge iClk or negedge iRst_n)
    if (!iRst_n) begin
      ldState <= L_IDLE;
      ldTag <= REG_ZERO;
      mduState <= M_IDLE;
      mduCnt <= '0;
    end else begin
      ldState <= ldNext;
      ldTag <= ldTagNext;
      mduState <= mduNext;
      mduCnt <= mduCntNext;
    end
endmodule

// File: tb/tb_decode_scoreboard.sv
// tb_decode_scoreboard: directed hazard scenarios with hand-computed expectations
module tb_decode_scoreboard;
  logic iClk = 0, iRst_n = 0;
  logic iValid, iFlush, iSrc0En, iSrc1En, iWriteEn, iMduOp, iFpuCmd, iLoadCmd, iLoadDone;
  logic [4:0] iSrc0Addr, iSrc1Addr, iWriteAddr;
  logic oStall, oMduBusy, oLoadBusy;
  logic [31:0] oPending;
  int checks = 0, errors = 0;

  decode_scoreboard dut (
    .iClk(iClk), .iRst_n(iRst_n), .iValid(iValid), .iFlush(iFlush),
    .iSrc0Addr(iSrc0Addr), .iSrc1Addr(iSrc1Addr), .iSrc0En(iSrc0En), .iSrc1En(iSrc1En),
    .iWriteAddr(iWriteAddr), .iWriteEn(iWriteEn), .iMduOp(iMduOp), .iFpuCmd(iFpuCmd),
    .iLoadCmd(iLoadCmd), .iLoadDone(iLoadDone), .oStall(oStall), .oPending(oPending),
    .oMduBusy(oMduBusy), .oLoadBusy(oLoadBusy)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    iValid = 0; iFlush = 0; iSrc0En = 0; iSrc1En = 0; iSrc0Addr = 0; iSrc1Addr = 0;
    iWriteAddr = 0; iWriteEn = 0; iMduOp = 0; iFpuCmd = 0; iLoadCmd = 0; iLoadDone = 0;
    #1;
  endtask

  task automatic instr(input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] wa,
                       input logic we, input logic mdu, input logic fpu, input logic ld, input logic fl);
    iValid = 1; iFlush = fl; iSrc0Addr = s0; iSrc0En = s0 != 0; iSrc1Addr = s1; iSrc1En = s1 != 0;
    iWriteAddr = wa; iWriteEn = we; iMduOp = mdu; iFpuCmd = fpu; iLoadCmd = ld; iLoadDone = 0;
    #1;
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  initial begin
    idle();
    repeat (2) step();
    check("rst_pending", oPending, 0);
    check("rst_mdubusy", oMduBusy, 0);
    check("rst_ldbusy", oLoadBusy, 0);
    check("rst_stall", oStall, 0);
    iRst_n = 1;
    step();
    // MDU RAW: MDU to r5, dependent read stalls 4 cycles
    instr(0, 0, 5, 1, 1, 0, 0, 0);
    check("mdu_issue_stall", oStall, 0);
    step();
    instr(5, 0, 6, 1, 0, 0, 0, 0);
    check("mdu_busy", oMduBusy, 1);
    for (int k = 1; k <= 4; k++) begin
      check("raw_mdu_stall", oStall, 1);
      check("raw_mdu_pend", oPending, 32'd1 << 5);
      step();
    end
    check("raw_mdu_release", oStall, 0);
    check("raw_mdu_idle", oMduBusy, 0);
    step();
    idle();
    // Load use: load r7, data back in the 6th cycle after issue
    instr(0, 0, 7, 1, 0, 0, 1, 0);
    step();
    check("ld_busy", oLoadBusy, 1);
    check("ld_pend", oPending, 32'd1 << 7);
    instr(0, 7, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      if (k == 6) begin iLoadDone = 1; #1; end
      check("ld_use_stall", oStall, 1);
      step();
    end
    iLoadDone = 0; #1;
    check("ld_use_release", oStall, 0);
    check("ld_busy_fall", oLoadBusy, 0);
    check("ld_pend_clear", oPending, 0);
    step();
    idle();
    // Structural MDU: r1 then r2
    instr(0, 0, 1, 1, 1, 0, 0, 0);
    step();
    instr(0, 0, 2, 1, 1, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      check("mdu_struct_stall", oStall, 1);
      step();
    end
    check("mdu_struct_release", oStall, 0);
    step();
    idle();
    check("mdu2_pend", oPending, 32'd1 << 2);
    check("mdu2_busy", oMduBusy, 1);
    repeat (4) step();
    check("mdu2_clear", oPending, 0);
    check("mdu2_idle", oMduBusy, 0);
    // Structural load: r8 then r9
    instr(0, 0, 8, 1, 0, 0, 1, 0);
    step();
    instr(0, 0, 9, 1, 0, 0, 1, 0);
    check("ld_struct_stall1", oStall, 1);
    step();
    iLoadDone = 1; #1;
    check("ld_struct_stall2", oStall, 1);
    step();
    iLoadDone = 0; #1;
    check("ld_struct_release", oStall, 0);
    step();
    idle();
    check("ld2_busy", oLoadBusy, 1);
    check("ld2_pend", oPending, 32'd1 << 9);
    iLoadDone = 1; #1;
    step();
    idle();
    check("ld2_done", oLoadBusy, 0);
    check("ld2_clear", oPending, 0);
    // WAW: FPU write r3 then ALU write r3
    instr(0, 0, 3, 1, 0, 1, 0, 0);
    step();
    instr(0, 0, 3, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      check("waw_stall", oStall, 1);
      check("waw_pend", oPending, 32'd1 << 3);
      step();
    end
    check("waw_release", oStall, 0);
    step();
    // r0 writes are never tracked, r0 reads never stall
    instr(0, 0, 0, 1, 0, 1, 0, 0);
    check("r0_fpu_stall", oStall, 0);
    step();
    instr(0, 0, 0, 1, 0, 0, 0, 0);
    check("r0_pend", oPending, 0);
    check("r0_waw", oStall, 0);
    step();
    idle();
    // Flush: stalled MDU flushed, then unstalled FPU/MDU flushed
    instr(0, 0, 10, 1, 1, 0, 0, 0);
    step();
    instr(0, 0, 11, 1, 1, 0, 0, 1);
    check("flush_stall_visible", oStall, 1);
    step();
    check("flush_no_r11", oPending, 32'd1 << 10);
    instr(0, 0, 12, 1, 0, 1, 0, 1);
    check("flush_fpu_nostall", oStall, 0);
    step();
    check("flush_no_r12", oPending, 32'd1 << 10);
    idle();
    repeat (2) step();
    check("flush_clear", oPending, 0);
    check("flush_mdu_idle", oMduBusy, 0);
    instr(0, 0, 13, 1, 1, 0, 0, 1);
    step();
    idle();
    check("flush_mdu_nofsm", oMduBusy, 0);
    check("flush_mdu_nopend", oPending, 0);
    // Async reset mid-operation drops all tracking
    instr(0, 0, 7, 1, 0, 0, 1, 0);
    step();
    instr(0, 0, 5, 1, 1, 0, 0, 0);
    check("pre_rst_nostall", oStall, 0);
    step();
    idle();
    check("pre_rst_pend", oPending, (32'd1 << 5) | (32'd1 << 7));
    #2 iRst_n = 0; #1;
    check("async_rst_pend", oPending, 0);
    check("async_rst_mdu", oMduBusy, 0);
    check("async_rst_ld", oLoadBusy, 0);
    step();
    iRst_n = 1;
    step();
    instr(5, 7, 0, 0, 1, 0, 1, 0);
    check("post_rst_nostall", oStall, 0);
    step();
    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
